mul_sched: RTL and testbench

MUL_SCHED -- requirements
Module: mul_sched

---
 rtl/mul_sched.sv | 200 ++++++++++++++++++++
 tb/tb_mul_sched.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_sched.sv
// mul_sched: round-robin scheduler that shares one multi-cycle mul_unit among
// NUM_REQ requesters, with per-requester kill and a one-entry response register.
module mul_sched #(
  parameter  int NUM_REQ = 2,
  parameter  int TAG_W   = 6,
  localparam int ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  input  logic [3*NUM_REQ-1:0]     req_func3_i,
  input  logic [NUM_REQ-1:0]       req_int_32_i,
  input  logic [64*NUM_REQ-1:0]    req_src1_i,
  input  logic [64*NUM_REQ-1:0]    req_src2_i,
  input  logic [TAG_W*NUM_REQ-1:0] req_tag_i,
  input  logic [NUM_REQ-1:0]       kill_i,
  output logic                     mul_request_o,
  output logic                     mul_kill_o,
  output logic [2:0]               mul_func3_o,
  output logic                     mul_int_32_o,
  output logic [63:0]              mul_src1_o,
  output logic [63:0]              mul_src2_o,
  input  logic [63:0]              mul_result_i,
  output logic                     resp_valid_o,
  input  logic                     resp_ready_i,
  output logic [ID_W-1:0]          resp_id_o,
  output logic [TAG_W-1:0]         resp_tag_o,
  output logic [63:0]              resp_data_o,
  output logic                     busy_o
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   last_grant_q;

  logic [2:0]        hold_func3_q;
  logic              hold_int_32_q;
  logic [63:0]       hold_src1_q;
  logic [63:0]       hold_src2_q;
  logic [TAG_W-1:0]  hold_tag_q;
  logic [ID_W-1:0]   hold_id_q;

  logic              resp_valid_q;
  logic [ID_W-1:0]   resp_id_q;
  logic [TAG_W-1:0]  resp_tag_q;
  logic [63:0]       resp_data_q;

  logic [2:0]        func3_a [NUM_REQ];
  logic [63:0]       src1_a  [NUM_REQ];
  logic [63:0]       src2_a  [NUM_REQ];
  logic [TAG_W-1:0]  tag_a   [NUM_REQ];

  logic [NUM_REQ-1:0] eligible;
  logic              grant_found;
  logic [ID_W-1:0]   grant_idx;
  logic              grant_fire;
  logic              owner_kill;
  logic              resp_load;
  int                cand;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign func3_a[g] = req_func3_i[g*3 +: 3];
    assign src1_a[g]  = req_src1_i[g*64 +: 64];
    assign src2_a[g]  = req_src2_i[g*64 +: 64];
    assign tag_a[g]   = req_tag_i[g*TAG_W +: TAG_W];
  end

  assign eligible = req_valid_i & ~kill_i;

  // Search starts one past the previous winner so every requester gets a turn.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = (int'(last_grant_q) + 1 + i) % NUM_REQ;
      if (!grant_found && eligible[cand]) begin
        grant_found = 1'b1;
        grant_idx   = ID_W'(cand);
      end
    end
  end

  // A killed response is hidden the same cycle; the register clears next edge.
  assign resp_valid_o = resp_valid_q & ~kill_i[resp_id_q];
  assign owner_kill   = kill_i[hold_id_q];

  // Gating with rstn_i keeps the combinational grant low while reset is held.
  assign grant_fire = rstn_i && (state_q == S_IDLE) && grant_found &&
                      (!resp_valid_o || resp_ready_i);

  always_comb begin
    req_ready_o = '0;
    if (grant_fire) req_ready_o[grant_idx] = 1'b1;
  end

  always_comb begin
    state_d       = state_q;
    mul_request_o = 1'b0;
    mul_kill_o    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (grant_fire) state_d = S_ISSUE;
      end
      S_ISSUE: begin
        if (owner_kill) begin
          mul_kill_o = 1'b1;
          state_d    = S_IDLE;
        end else begin
          mul_request_o = 1'b1;
          state_d       = S_WAIT;
        end
      end
      S_WAIT: begin
        if (owner_kill) begin
          mul_kill_o = 1'b1;
          state_d    = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        mul_kill_o = owner_kill;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign resp_load = (state_q == S_DONE) && !owner_kill;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q      <= S_IDLE;
      last_grant_q <= ID_W'(NUM_REQ - 1);
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of statement order.
      state_q <= state_d;
      if (grant_fire) last_grant_q <= grant_idx;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      // NOTE: the operand hold registers drive outputs directly, so they are
      // reset to give all-zero outputs under reset.
      hold_func3_q  <= '0;
      hold_int_32_q <= 1'b0;
      hold_src1_q   <= '0;
      hold_src2_q   <= '0;
      hold_tag_q    <= '0;
      hold_id_q     <= '0;
    end else if (grant_fire) begin
      hold_func3_q  <= func3_a[grant_idx];
      hold_int_32_q <= req_int_32_i[grant_idx];
      hold_src1_q   <= src1_a[grant_idx];
      hold_src2_q   <= src2_a[grant_idx];
      hold_tag_q    <= tag_a[grant_idx];
      hold_id_q     <= grant_idx;
    end
  end

  // The response slot is always empty by DONE: a grant requires it free or
  // draining, so load and clear never compete.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_tag_q   <= '0;
      resp_data_q  <= '0;
    end else if (resp_load) begin
      resp_valid_q <= 1'b1;
      resp_id_q    <= hold_id_q;
      resp_tag_q   <= hold_tag_q;
      resp_data_q  <= mul_result_i;
    end else if (resp_valid_q && (resp_ready_i || kill_i[resp_id_q])) begin
      resp_valid_q <= 1'b0;
    end
  end

  assign mul_func3_o  = hold_func3_q;
  assign mul_int_32_o = hold_int_32_q;
  assign mul_src1_o   = hold_src1_q;
  assign mul_src2_o   = hold_src2_q;
  assign resp_id_o    = resp_id_q;
  assign resp_tag_o   = resp_tag_q;
  assign resp_data_o  = resp_data_q;
  assign busy_o       = (state_q != S_IDLE);

endmodule

// File: tb/tb_mul_sched.sv
// Directed self-checking bench for mul_sched with a behavioural mul_unit model
// answering from the scheduler's operand outputs.
module tb_mul_sched;

  localparam int NUM_REQ = 2;
  localparam int TAG_W   = 6;
  localparam int ID_W    = 1;

  logic                     clk_i = 1'b0;
  logic                     rstn_i;
  logic [NUM_REQ-1:0]       req_valid_i;
  logic [NUM_REQ-1:0]       req_ready_o;
  logic [3*NUM_REQ-1:0]     req_func3_i;
  logic [NUM_REQ-1:0]       req_int_32_i;
  logic [64*NUM_REQ-1:0]    req_src1_i;
  logic [64*NUM_REQ-1:0]    req_src2_i;
  logic [TAG_W*NUM_REQ-1:0] req_tag_i;
  logic [NUM_REQ-1:0]       kill_i;
  logic                     mul_request_o;
  logic                     mul_kill_o;
  logic [2:0]               mul_func3_o;
  logic                     mul_int_32_o;
  logic [63:0]              mul_src1_o;
  logic [63:0]              mul_src2_o;
  logic [63:0]              mul_result_i;
  logic                     resp_valid_o;
  logic                     resp_ready_i;
  logic [ID_W-1:0]          resp_id_o;
  logic [TAG_W-1:0]         resp_tag_o;
  logic [63:0]              resp_data_o;
  logic                     busy_o;

  int n_checks = 0;
  int n_fail   = 0;

  mul_sched #(.NUM_REQ(NUM_REQ), .TAG_W(TAG_W)) dut (
    .clk_i         (clk_i),
    .rstn_i        (rstn_i),
    .req_valid_i   (req_valid_i),
    .req_ready_o   (req_ready_o),
    .req_func3_i   (req_func3_i),
    .req_int_32_i  (req_int_32_i),
    .req_src1_i    (req_src1_i),
    .req_src2_i    (req_src2_i),
    .req_tag_i     (req_tag_i),
    .kill_i        (kill_i),
    .mul_request_o (mul_request_o),
    .mul_kill_o    (mul_kill_o),
    .mul_func3_o   (mul_func3_o),
    .mul_int_32_o  (mul_int_32_o),
    .mul_src1_o    (mul_src1_o),
    .mul_src2_o    (mul_src2_o),
    .mul_result_i  (mul_result_i),
    .resp_valid_o  (resp_valid_o),
    .resp_ready_i  (resp_ready_i),
    .resp_id_o     (resp_id_o),
    .resp_tag_o    (resp_tag_o),
    .resp_data_o   (resp_data_o),
    .busy_o        (busy_o)
  );

  always #5 clk_i = ~clk_i;

  // mul_unit stand-in: RISC-V MUL/MULH/MULHSU/MULHU and MULW semantics.
  logic [127:0] op_a, op_b, prod;
  logic [31:0]  prod_w;
  always_comb begin
    op_a = {64'b0, mul_src1_o};
    op_b = {64'b0, mul_src2_o};
    if (mul_func3_o == 3'd1 || mul_func3_o == 3'd2) op_a = {{64{mul_src1_o[63]}}, mul_src1_o};
    if (mul_func3_o == 3'd1) op_b = {{64{mul_src2_o[63]}}, mul_src2_o};
    prod   = op_a * op_b;
    prod_w = mul_src1_o[31:0] * mul_src2_o[31:0];
    if (mul_int_32_o)             mul_result_i = {{32{prod_w[31]}}, prod_w};
    else if (mul_func3_o == 3'd0) mul_result_i = prod[63:0];
    else                          mul_result_i = prod[127:64];
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int r, input logic v, input logic [2:0] f3, input logic w,
                         input logic [63:0] a, input logic [63:0] b, input logic [TAG_W-1:0] t);
    req_valid_i[r]              = v;
    req_func3_i[r*3 +: 3]       = f3;
    req_int_32_i[r]             = w;
    req_src1_i[r*64 +: 64]      = a;
    req_src2_i[r*64 +: 64]      = b;
    req_tag_i[r*TAG_W +: TAG_W] = t;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic smp();
    @(negedge clk_i);
  endtask

  task automatic reset_assert();
    rstn_i       = 1'b0;
    req_valid_i  = '0;
    req_func3_i  = '0;
    req_int_32_i = '0;
    req_src1_i   = '0;
    req_src2_i   = '0;
    req_tag_i    = '0;
    kill_i       = '0;
    resp_ready_i = 1'b1;
  endtask

  task automatic reset_release();
    repeat (2) @(posedge clk_i);
    #1;
    rstn_i = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] exp_rdy;
    int         owner;

    // Reset state, with a pending request that must not be granted
    reset_assert();
    req_valid_i[0] = 1'b1;
    smp();
    check("rst_ready", req_ready_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_mul_request", mul_request_o, 0);
    check("rst_resp_valid", resp_valid_o, 0);
    check("rst_src1", mul_src1_o, 0);
    req_valid_i = '0;
    reset_release();

    // Single MUL 7 * -3
    set_req(0, 1'b1, 3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 6'd5);
    smp();
    check("single_ready_T", req_ready_o, 2'b01);
    tick();
    req_valid_i[0] = 1'b0;
    smp();
    check("single_request_T1", mul_request_o, 1);
    check("single_src1_T1", mul_src1_o, 64'd7);
    check("single_src2_T1", mul_src2_o, 64'hFFFF_FFFF_FFFF_FFFD);
    check("single_busy_T1", busy_o, 1);
    tick();
    smp();
    check("single_request_T2", mul_request_o, 0);
    check("single_busy_T2", busy_o, 1);
    tick();
    smp();
    check("single_resp_T3", resp_valid_o, 0);
    tick();
    smp();
    check("single_resp_T4", resp_valid_o, 1);
    check("single_data", resp_data_o, 64'hFFFF_FFFF_FFFF_FFEB);
    check("single_id", resp_id_o, 0);
    check("single_tag", resp_tag_o, 5);
    check("single_busy_T4", busy_o, 0);
    tick();
    smp();
    check("single_resp_T5", resp_valid_o, 0);

    // Contention from reset: grants every 4 cycles, alternating 0,1,0,1,0
    tick();
    reset_assert();
    set_req(0, 1'b1, 3'd0, 1'b0, 64'd3, 64'd4, 6'd10);
    set_req(1, 1'b1, 3'd0, 1'b0, 64'd5, 64'd6, 6'd20);
    reset_release();
    for (int c = 0; c <= 16; c++) begin
      smp();
      exp_rdy = (c % 4 != 0) ? 2'b00 : (((c / 4) % 2 == 0) ? 2'b01 : 2'b10);
      check($sformatf("rr_ready_c%0d", c), req_ready_o, exp_rdy);
      if (c % 4 == 0 && c > 0) begin
        owner = (c / 4 - 1) % 2;
        check($sformatf("rr_resp_valid_c%0d", c), resp_valid_o, 1);
        check($sformatf("rr_resp_id_c%0d", c), resp_id_o, owner);
        check($sformatf("rr_resp_tag_c%0d", c), resp_tag_o, owner ? 20 : 10);
        check($sformatf("rr_resp_data_c%0d", c), resp_data_o, owner ? 30 : 12);
      end
      tick();
    end

    // Kill of req1 MULHU in WAIT, then req0 op with a non-owner kill
    reset_assert();
    reset_release();
    set_req(1, 1'b1, 3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 6'd9);
    smp();
    check("kill_ready_T", req_ready_o, 2'b10);
    tick();
    req_valid_i[1] = 1'b0;
    smp();
    check("kill_request_T1", mul_request_o, 1);
    check("kill_func3_T1", mul_func3_o, 3);
    tick();
    kill_i = 2'b10;
    smp();
    check("kill_mul_kill_T2", mul_kill_o, 1);
    check("kill_request_T2", mul_request_o, 0);
    tick();
    kill_i = 2'b00;
    set_req(0, 1'b1, 3'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFFA, 6'd3);
    smp();
    check("kill_busy_T3", busy_o, 0);
    check("kill_resp_T3", resp_valid_o, 0);
    check("kill_regrant_T3", req_ready_o, 2'b01);
    tick();
    req_valid_i[0] = 1'b0;
    smp();
    check("nokill_request", mul_request_o, 1);
    check("nokill_resp_early", resp_valid_o, 0);
    tick();
    kill_i = 2'b10;
    smp();
    check("nokill_mul_kill", mul_kill_o, 0);
    check("nokill_busy", busy_o, 1);
    tick();
    kill_i = 2'b00;
    smp();
    check("nokill_resp_done", resp_valid_o, 0);
    tick();
    smp();
    check("nokill_resp_valid", resp_valid_o, 1);
    check("nokill_resp_id", resp_id_o, 0);
    check("nokill_resp_tag", resp_tag_o, 3);
    check("nokill_resp_data", resp_data_o, 64'd30);
    tick();

    // Backpressure: response held 10 cycles, then handshake and regrant together
    reset_assert();
    reset_release();
    resp_ready_i = 1'b0;
    set_req(0, 1'b1, 3'd0, 1'b0, 64'd9, 64'd9, 6'd1);
    smp();
    check("bp_ready_T", req_ready_o, 2'b01);
    tick();
    set_req(0, 1'b1, 3'd0, 1'b0, 64'd2, 64'd8, 6'd2);
    for (int i = 1; i <= 3; i++) begin
      smp();
      check($sformatf("bp_ready_T%0d", i), req_ready_o, 0);
      tick();
    end
    for (int i = 4; i <= 13; i++) begin
      smp();
      check($sformatf("bp_valid_T%0d", i), resp_valid_o, 1);
      check($sformatf("bp_data_T%0d", i), resp_data_o, 64'd81);
      check($sformatf("bp_tag_T%0d", i), resp_tag_o, 1);
      check($sformatf("bp_ready_T%0d", i), req_ready_o, 0);
      tick();
    end
    resp_ready_i = 1'b1;
    smp();
    check("bp_handshake_valid", resp_valid_o, 1);
    check("bp_handshake_grant", req_ready_o, 2'b01);
    tick();
    req_valid_i[0] = 1'b0;
    smp();
    check("bp_cleared", resp_valid_o, 0);
    check("bp_request2", mul_request_o, 1);
    check("bp_src1_2", mul_src1_o, 64'd2);
    repeat (3) tick();
    smp();
    check("bp_resp2_valid", resp_valid_o, 1);
    check("bp_resp2_data", resp_data_o, 64'd16);
    check("bp_resp2_tag", resp_tag_o, 2);
    tick();

    // MULW overflow result, then response killed while waiting
    reset_assert();
    reset_release();
    resp_ready_i = 1'b0;
    set_req(0, 1'b1, 3'd0, 1'b1, 64'h0000_0000_7FFF_FFFF, 64'd2, 6'd7);
    smp();
    check("mulw_ready", req_ready_o, 2'b01);
    tick();
    req_valid_i[0] = 1'b0;
    repeat (3) tick();
    smp();
    check("mulw_valid", resp_valid_o, 1);
    check("mulw_data", resp_data_o, 64'hFFFF_FFFF_FFFF_FFFE);
    tick();
    smp();
    check("mulw_hold", resp_valid_o, 1);
    tick();
    kill_i = 2'b01;
    smp();
    check("rkill_masked", resp_valid_o, 0);
    tick();
    kill_i = 2'b00;
    smp();
    check("rkill_cleared", resp_valid_o, 0);
    tick();
    smp();
    check("rkill_stays", resp_valid_o, 0);
    tick();

    // Reset asserted in DONE
    reset_assert();
    reset_release();
    set_req(0, 1'b1, 3'd0, 1'b0, 64'd11, 64'd3, 6'd4);
    smp();
    check("rdone_ready", req_ready_o, 2'b01);
    tick();
    req_valid_i[0] = 1'b0;
    tick();
    tick();
    smp();
    check("rdone_busy", busy_o, 1);
    #1;
    req_valid_i[0] = 1'b1;
    rstn_i = 1'b0;
    #1;
    check("rdone_ready_rst", req_ready_o, 0);
    check("rdone_busy_rst", busy_o, 0);
    check("rdone_request_rst", mul_request_o, 0);
    check("rdone_kill_rst", mul_kill_o, 0);
    check("rdone_func3_rst", mul_func3_o, 0);
    check("rdone_int32_rst", mul_int_32_o, 0);
    check("rdone_src1_rst", mul_src1_o, 0);
    check("rdone_src2_rst", mul_src2_o, 0);
    check("rdone_resp_valid_rst", resp_valid_o, 0);
    check("rdone_resp_id_rst", resp_id_o, 0);
    check("rdone_resp_tag_rst", resp_tag_o, 0);
    check("rdone_resp_data_rst", resp_data_o, 0);
    req_valid_i[0] = 1'b0;
    reset_release();
    for (int i = 0; i < 6; i++) begin
      smp();
      check($sformatf("rdone_after_valid_%0d", i), resp_valid_o, 0);
      check($sformatf("rdone_after_busy_%0d", i), busy_o, 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
